// File: rtl/pet_state_core.sv
// rtl/pet_state_core.sv - tamagotchi game engine: tick prescaler, hunger/boredom ageing, mood FSM, 7-seg glyph
module pet_state_core #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int STAT_W     = 4,
    parameter int STAT_MAX   = 15,
    parameter int HUNGRY_TH  = 8,
    parameter int BORED_TH   = 8,
    parameter int FEED_STEP  = 4,
    parameter int PLAY_STEP  = 4,
    parameter int SICK_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              feed,
    input  logic              play,
    output logic [6:0]        seg,
    output logic [2:0]        state,
    output logic [STAT_W-1:0] hunger,
    output logic [STAT_W-1:0] boredom,
    output logic              tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(SICK_TICKS + 1);
    localparam int SW = STAT_W + 2;

    localparam logic [6:0] GLYPH_U     = 7'b0111110;
    localparam logic [6:0] GLYPH_H     = 7'b1110110;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_S     = 7'b1101101;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;

    typedef logic signed [SW-1:0] sval_t;

    typedef enum logic [2:0] {
        S_HAPPY  = 3'd0,
        S_HUNGRY = 3'd1,
        S_BORED  = 3'd2,
        S_SICK   = 3'd3,
        S_DEAD   = 3'd4
    } mood_t;

    mood_t          cur, nxt;
    logic [PW-1:0]  presc;
    logic [CW-1:0]  sick_cnt;
    logic           blink;
    logic [6:0]     seg_next;

    // Signed arithmetic with two spare bits so tick+step in either direction never wraps.
    function automatic logic [STAT_W-1:0] step_stat(input logic [STAT_W-1:0] v,
                                                     input logic inc, input logic dec,
                                                     input int amt);
        sval_t s;
        s = sval_t'({2'b00, v}) + sval_t'({{(SW-1){1'b0}}, inc})
            - (dec ? sval_t'(amt) : sval_t'(0));
        if (s < 0)
            return '0;
        else if (s > sval_t'(STAT_MAX))
            return STAT_W'(STAT_MAX);
        else
            return s[STAT_W-1:0];
    endfunction

    always_comb begin
        nxt = cur;
        if (cur == S_DEAD)
            nxt = S_DEAD;
        else if (sick_cnt == CW'(SICK_TICKS))
            nxt = S_DEAD;
        else if (hunger == STAT_W'(STAT_MAX) || boredom == STAT_W'(STAT_MAX))
            nxt = S_SICK;
        else if (hunger >= STAT_W'(HUNGRY_TH))
            nxt = S_HUNGRY;
        else if (boredom >= STAT_W'(BORED_TH))
            nxt = S_BORED;
        else
            nxt = S_HAPPY;
    end

    always_comb begin
        seg_next = GLYPH_U;
        case (cur)
            S_HAPPY:  seg_next = GLYPH_U;
            S_HUNGRY: seg_next = GLYPH_H;
            S_BORED:  seg_next = GLYPH_B;
            S_SICK:   seg_next = blink ? GLYPH_S : 7'b0000000;
            S_DEAD:   seg_next = GLYPH_DASH;
            default:  seg_next = GLYPH_U;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            tick     <= 1'b0;
            hunger   <= '0;
            boredom  <= '0;
            sick_cnt <= '0;
            blink    <= 1'b1;
            cur      <= S_HAPPY;
            seg      <= GLYPH_U;
        end else begin
            tick  <= (presc == PW'(TICK_DIV - 1));
            presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
            blink <= blink ^ tick;
            seg   <= seg_next;
            cur   <= nxt;
            // Once dead everything but the prescaler and blink is frozen until reset.
            if (cur != S_DEAD) begin
                hunger  <= step_stat(hunger, tick, feed, FEED_STEP);
                boredom <= step_stat(boredom, tick, play, PLAY_STEP);
                if (cur == S_SICK && nxt == S_SICK) begin
                    if (tick && sick_cnt != CW'(SICK_TICKS))
                        sick_cnt <= sick_cnt + 1'b1;
                end else begin
                    sick_cnt <= '0;
                end
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pet_state_core.sv
// tb/tb_pet_state_core.sv - randomized scoreboard bench for pet_state_core against a behavioural pet model
module tb_pet_state_core;

    localparam int HAPPY = 0, HUNGRY = 1, BORED = 2, SICK = 3, DEAD = 4;

    logic       clk = 1'b0;
    logic       rst, feed, play;
    logic [6:0] seg;
    logic [2:0] state;
    logic [3:0] hunger, boredom;
    logic       tick;

    pet_state_core #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .feed(feed), .play(play),
        .seg(seg), .state(state), .hunger(hunger), .boredom(boredom), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t; int st; int h; int b; int sg;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: cycles since reset, stats as plain integers, mood derived by rule.
    int m_cyc, m_tick, m_h, m_b, m_sick, m_blink, m_mood, m_seg;

    function automatic int clamp15(input int v);
        return (v < 0) ? 0 : (v > 15) ? 15 : v;
    endfunction

    function automatic int glyph(input int mood, input int blink);
        case (mood)
            HAPPY:   return 'h3E;
            HUNGRY:  return 'h76;
            BORED:   return 'h7C;
            SICK:    return blink ? 'h6D : 'h00;
            default: return 'h40;
        endcase
    endfunction

    function automatic int mood_rule(input int h, input int b, input int sick, input int cur);
        if (cur == DEAD || sick >= 8) return DEAD;
        if (h == 15 || b == 15)       return SICK;
        if (h >= 8)                   return HUNGRY;
        if (b >= 8)                   return BORED;
        return HAPPY;
    endfunction

    task automatic model_step(input bit r, input bit f, input bit p);
        int nh, nb, nm, nsk, nseg, nblink, ntick;
        if (r) begin
            m_cyc = 0; m_tick = 0; m_h = 0; m_b = 0; m_sick = 0;
            m_blink = 1; m_mood = HAPPY; m_seg = 'h3E;
        end else begin
            m_cyc  = m_cyc + 1;
            ntick  = (m_cyc % 4 == 0) ? 1 : 0;
            nseg   = glyph(m_mood, m_blink);
            nblink = m_blink ^ m_tick;
            nh = m_h; nb = m_b; nm = m_mood; nsk = m_sick;
            if (m_mood != DEAD) begin
                nh  = clamp15(m_h + m_tick - (f ? 4 : 0));
                nb  = clamp15(m_b + m_tick - (p ? 4 : 0));
                nm  = mood_rule(m_h, m_b, m_sick, m_mood);
                nsk = (m_mood == SICK && nm == SICK) ? ((m_sick + m_tick > 8) ? 8 : m_sick + m_tick) : 0;
            end
            m_tick = ntick; m_h = nh; m_b = nb; m_mood = nm;
            m_sick = nsk; m_seg = nseg; m_blink = nblink;
        end
        q.push_back('{t: m_tick, st: m_mood, h: m_h, b: m_b, sg: m_seg});
    endtask

    task automatic drive(input bit r, input bit f, input bit p);
        @(negedge clk);
        rst = r; feed = f; play = p;
        model_step(r, f, p);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("tick",    {31'b0, tick},    e.t);
                chk("state",   {29'b0, state},   e.st);
                chk("hunger",  {28'b0, hunger},  e.h);
                chk("boredom", {28'b0, boredom}, e.b);
                chk("seg",     {25'b0, seg},     e.sg);
            end
        end
    end

    // Feed/play probabilities (percent per cycle) per phase; zeros let the pet starve to death.
    int feed_pct[12] = '{0, 3, 10, 30, 0, 6, 2, 15, 0, 8, 50, 1};
    int play_pct[12] = '{0, 10, 3, 30, 0, 2, 6, 15, 5, 0, 50, 1};

    initial begin : stimulus
        bit r, f, p;
        rst = 1'b1; feed = 1'b0; play = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        for (int ph = 0; ph < 12; ph++) begin
            for (int c = 0; c < 220; c++) begin
                r = (c == 0 && ph % 3 == 0) || ($urandom_range(0, 499) == 0);
                f = ($urandom_range(0, 99) < feed_pct[ph]);
                p = ($urandom_range(0, 99) < play_pct[ph]);
                drive(r, f, p);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 10 && q.size() != 0; w++) begin
            @(posedge clk);
            #2;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
